// File: rtl/rv_pkg.sv
// Shared RV core constants and typedefs (register file, writeback, issue).
package rv_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned RV_AW   = 5;
    localparam int unsigned RV_NREG = 1 << RV_AW;

    typedef logic [RV_AW-1:0]   reg_addr_t;
    typedef logic [RV_XLEN-1:0] xlen_t;
    typedef logic [31:0]        stall_cnt_t;

    localparam stall_cnt_t STALL_MAX = '1;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight destinations and flags
// RAW (rs1/rs2) and WAW (rd) hazards against them.
module hazard_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned AW = RV_AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic [AW-1:0] i_rd,
    input  logic          i_use_rs1,
    input  logic          i_use_rs2,
    input  logic          i_rd_we,
    input  logic          i_set_en,
    input  logic          i_wb_clr,
    input  logic [AW-1:0] i_wb_rd,
    input  logic          i_fl_clr,
    input  logic [AW-1:0] i_fl_rd,
    output logic          o_hz1,
    output logic          o_hz2,
    output logic          o_hzw
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_fl_mask;
    logic [NREG-1:0] w_effbusy;
    logic [NREG-1:0] w_busy_nxt;

    // Decode set / writeback-clear / flush-clear requests into one-hot masks
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        w_fl_mask  = '0;
        if (i_set_en && i_rd_we && (i_rd != '0))
            w_set_mask[i_rd] = 1'b1;
        if (i_wb_clr)
            w_clr_mask[i_wb_rd] = 1'b1;
        if (i_fl_clr && (i_fl_rd != '0))
            w_fl_mask[i_fl_rd] = 1'b1;
    end

    // A register being written back this cycle is already free for readers
    assign w_effbusy = r_busy & ~w_clr_mask;

    assign o_hz1 = i_use_rs1 && (i_rs1 != '0) && w_effbusy[i_rs1];
    assign o_hz2 = i_use_rs2 && (i_rs2 != '0) && w_effbusy[i_rs2];
    assign o_hzw = i_rd_we   && (i_rd  != '0) && w_effbusy[i_rd];

    // Set wins over a same-cycle clear (WAW release re-claiming the register)
    assign w_busy_nxt = (r_busy & ~w_clr_mask & ~w_fl_mask) | w_set_mask;

    // Busy vector; x0 never tracked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_busy <= '0;
        else
            r_busy <= {w_busy_nxt[NREG-1:1], 1'b0};
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: register-file read, writeback bypass, hazard stall and a
// single registered output slot towards EX.
module operand_fetch
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = RV_XLEN,
    parameter int unsigned AW   = RV_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    output logic [AW-1:0]   rR1,
    output logic [AW-1:0]   rR2,
    input  logic [XLEN-1:0] rD1,
    input  logic [XLEN-1:0] rD2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_we,
    input  logic            flush,
    output logic [31:0]     stall_cnt
);

    logic            w_wb_clr;
    logic            w_hz1;
    logic            w_hz2;
    logic            w_hzw;
    logic            w_slot_free;
    logic            w_issue;
    logic            w_fl_clr;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_op1;
    logic [XLEN-1:0] r_ex_op2;
    logic [AW-1:0]   r_ex_rd;
    logic            r_ex_rd_we;
    stall_cnt_t      r_stall_cnt;

    assign rR1 = id_rs1;
    assign rR2 = id_rs2;

    assign w_wb_clr    = wb_we && (wb_rd != '0);
    assign w_slot_free = !r_ex_valid || ex_ready;
    assign id_ready    = id_valid && w_slot_free && !w_hz1 && !w_hz2 && !w_hzw && !flush;
    assign w_issue     = id_ready;
    assign w_fl_clr    = flush && r_ex_valid && r_ex_rd_we;

    hazard_scoreboard #(
        .AW (AW)
    ) u_sb (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rs1     (id_rs1),
        .i_rs2     (id_rs2),
        .i_rd      (id_rd),
        .i_use_rs1 (id_use_rs1),
        .i_use_rs2 (id_use_rs2),
        .i_rd_we   (id_rd_we),
        .i_set_en  (w_issue),
        .i_wb_clr  (w_wb_clr),
        .i_wb_rd   (wb_rd),
        .i_fl_clr  (w_fl_clr),
        .i_fl_rd   (r_ex_rd),
        .o_hz1     (w_hz1),
        .o_hz2     (w_hz2),
        .o_hzw     (w_hzw)
    );

    // Operand select: x0 -> 0, same-cycle writeback bypass, else register file
    always_comb begin
        w_op1 = rD1;
        w_op2 = rD2;
        if (id_rs1 == '0)
            w_op1 = '0;
        else if (w_wb_clr && (wb_rd == id_rs1))
            w_op1 = wb_data;
        if (id_rs2 == '0)
            w_op2 = '0;
        else if (w_wb_clr && (wb_rd == id_rs2))
            w_op2 = wb_data;
    end

    // Output slot: flush kills, issue loads, consume empties, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_rd    <= '0;
            r_ex_rd_we <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
            r_ex_rd    <= id_rd;
            r_ex_rd_we <= id_rd_we;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where decode is held back (flush excluded)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (id_valid && !id_ready && !flush && (r_stall_cnt != STALL_MAX))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign ex_valid  = r_ex_valid;
    assign ex_op1    = r_ex_op1;
    assign ex_op2    = r_ex_op2;
    assign ex_rd     = r_ex_rd;
    assign ex_rd_we  = r_ex_rd_we;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus multi-cycle sequences.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic [31:0] rD1;
    logic [31:0] rD2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        flush;
    logic [31:0] stall_cnt;

    operand_fetch #(.XLEN(32), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_rd_we   (id_rd_we),
        .rR1        (rR1),
        .rR2        (rR2),
        .rD1        (rD1),
        .rD2        (rD2),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_rd      (ex_rd),
        .ex_rd_we   (ex_rd_we),
        .flush      (flush),
        .stall_cnt  (stall_cnt)
    );

    logic [31:0] busy_v;
    assign busy_v = dut.u_sb.r_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x0 reads a junk value so the x0 mux is exercised
    logic [31:0] rf [32];

    function automatic logic [31:0] rf_init(input int unsigned i);
        case (i)
            0:       rf_init = 32'hDEAD_BEEF;
            6:       rf_init = 32'h6060_6060;
            default: rf_init = i * 32'h1111_1111;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (wb_we && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign rD1 = rf[rR1];
    assign rD2 = rf[rR2];

    int total;
    int bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic we, input logic u1, input logic u2);
        id_valid   = 1'b1;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        id_rd_we   = we;
        id_use_rs1 = u1;
        id_use_rs2 = u2;
    endtask

    task automatic idle;
        id_valid   = 1'b0;
        id_rs1     = '0;
        id_rs2     = '0;
        id_rd      = '0;
        id_rd_we   = 1'b0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        wb_we      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
    endtask

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        u1;
        logic        u2;
        logic        wbe;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_rd;
        logic [31:0] e_busy;
        logic [31:0] e_stall;
    } vec_t;

    vec_t tv [6];

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b0;

        //       rs1 rs2 rd we u1 u2 wbe wrd wd            rdy val op1           op2           erd busy          stall
        tv[0] = '{1, 2, 3, 1, 1, 1, 0, 0, 32'h0,          1, 1, 32'h1111_1111, 32'h2222_2222, 3, 32'h0000_0008, 0};
        tv[1] = '{4, 0, 0, 1, 1, 1, 1, 3, 32'h3333_0000,  1, 1, 32'h4444_4444, 32'h0,         0, 32'h0000_0000, 0};
        tv[2] = '{3, 6, 8, 1, 1, 1, 1, 6, 32'h6666_0000,  1, 1, 32'h3333_0000, 32'h6666_0000, 8, 32'h0000_0100, 0};
        tv[3] = '{0, 0, 0, 0, 1, 1, 1, 0, 32'hFFFF_FFFF,  1, 1, 32'h0,         32'h0,         0, 32'h0000_0100, 0};
        tv[4] = '{8, 2, 9, 1, 0, 1, 0, 0, 32'h0,          1, 1, 32'h8888_8888, 32'h2222_2222, 9, 32'h0000_0300, 0};
        tv[5] = '{9, 0, 10, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h8888_8888, 32'h2222_2222, 9, 32'h0000_0300, 1};

        // Reset values
        tick();
        tick();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        chk("rst_ex_op2", ex_op2, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ex_rd_we", {31'd0, ex_rd_we}, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_busy", busy_v, 32'd0);
        rst_n = 1'b1;

        // Vector table, ex_ready held high
        for (int i = 0; i < 6; i++) begin
            present(tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].we, tv[i].u1, tv[i].u2);
            wb_we   = tv[i].wbe;
            wb_rd   = tv[i].wrd;
            wb_data = tv[i].wd;
            #2;
            chk($sformatf("v%0d_ready", i), {31'd0, id_ready}, {31'd0, tv[i].e_rdy});
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, tv[i].e_val});
            chk($sformatf("v%0d_op1", i), ex_op1, tv[i].e_op1);
            chk($sformatf("v%0d_op2", i), ex_op2, tv[i].e_op2);
            chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, tv[i].e_rd});
            chk($sformatf("v%0d_busy", i), busy_v, tv[i].e_busy);
            chk($sformatf("v%0d_stall", i), stall_cnt, tv[i].e_stall);
        end
        idle();

        // RAW stall released by same-cycle writeback
        rst_n = 1'b0;
        #1;
        chk("A_rst_busy", busy_v, 32'd0);
        chk("A_rst_stall", stall_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        present(1, 2, 3, 1, 1, 1);
        #2;
        chk("A_iss_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("A_valid", {31'd0, ex_valid}, 32'd1);
        chk("A_op1", ex_op1, 32'h1111_1111);
        chk("A_op2", ex_op2, 32'h2222_2222);
        chk("A_busy3", {31'd0, busy_v[3]}, 32'd1);
        present(3, 0, 10, 1, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk($sformatf("A_stall_ready%0d", k), {31'd0, id_ready}, 32'd0);
            tick();
            chk($sformatf("A_stall_cnt%0d", k), stall_cnt, k);
        end
        wb_we   = 1'b1;
        wb_rd   = 5'd3;
        wb_data = 32'h0D00_0721;
        #2;
        chk("A_wb_ready", {31'd0, id_ready}, 32'd1);
        tick();
        wb_we = 1'b0;
        chk("A_byp_op1", ex_op1, 32'h0D00_0721);
        chk("A_busy3_clr", {31'd0, busy_v[3]}, 32'd0);
        chk("A_busy10", {31'd0, busy_v[10]}, 32'd1);
        chk("A_stall_hold", stall_cnt, 32'd3);

        // Backpressure: slot full, EX not ready
        ex_ready = 1'b0;
        present(1, 0, 11, 1, 1, 0);
        for (int k = 1; k <= 2; k++) begin
            #2;
            chk($sformatf("B_ready%0d", k), {31'd0, id_ready}, 32'd0);
            tick();
            chk($sformatf("B_hold_op1_%0d", k), ex_op1, 32'h0D00_0721);
            chk($sformatf("B_hold_rd_%0d", k), {27'd0, ex_rd}, 32'd10);
            chk($sformatf("B_hold_valid_%0d", k), {31'd0, ex_valid}, 32'd1);
        end
        chk("B_stall", stall_cnt, 32'd5);
        ex_ready = 1'b1;
        #2;
        chk("B_rel_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("B_new_op1", ex_op1, 32'h1111_1111);
        chk("B_new_rd", {27'd0, ex_rd}, 32'd11);

        // Flush kills slot and releases its destination
        present(0, 0, 5, 1, 0, 0);
        #2;
        tick();
        chk("C_busy5", {31'd0, busy_v[5]}, 32'd1);
        chk("C_rd5", {27'd0, ex_rd}, 32'd5);
        flush = 1'b1;
        present(5, 0, 12, 1, 1, 0);
        #2;
        chk("C_fl_ready", {31'd0, id_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("C_fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("C_fl_busy5", {31'd0, busy_v[5]}, 32'd0);
        chk("C_fl_busy12", {31'd0, busy_v[12]}, 32'd0);
        chk("C_fl_stall", stall_cnt, 32'd5);
        #2;
        chk("C_after_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("C_after_op1", ex_op1, 32'h5555_5555);
        chk("C_after_valid", {31'd0, ex_valid}, 32'd1);

        // WAW on x7, then reset while stalled with a full slot
        present(0, 0, 7, 1, 0, 0);
        #2;
        chk("D_first_ready", {31'd0, id_ready}, 32'd1);
        tick();
        #2;
        chk("D_waw_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("D_waw_stall", stall_cnt, 32'd6);
        wb_we   = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'h0000_0077;
        #2;
        chk("D_rel_ready", {31'd0, id_ready}, 32'd1);
        tick();
        wb_we = 1'b0;
        chk("D_busy7_reset", {31'd0, busy_v[7]}, 32'd1);
        chk("D_rd7", {27'd0, ex_rd}, 32'd7);
        ex_ready = 1'b0;
        tick();
        tick();
        chk("D_stall8", stall_cnt, 32'd8);
        chk("D_full", {31'd0, ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("D_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("D_rst_busy", busy_v, 32'd0);
        chk("D_rst_stall", stall_cnt, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
